prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 35 +++
 rtl/prog_loader_if.sv | 31 +++
 rtl/prog_loader.sv | 128 ++++++++++++
 tb/tb_prog_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared loader definitions: bus widths, opcode values, state encoding and
// the payload layout of one instruction word.
package loader_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned ADDR_BITS  = 8;
  localparam int unsigned WORD_BITS  = 2 * DATA_BITS;
  localparam int unsigned COUNT_BITS = 8;

  localparam logic [DATA_BITS-1:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [DATA_BITS-1:0] {
    OP_NOP  = 8'h00,
    OP_LOAD = 8'h10,
    OP_ADD  = 8'h20,
    OP_JMP  = 8'h30
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] opcode;
    logic [DATA_BITS-1:0] operand;
  } prog_word_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, instruction-memory write port out. The loader is the slave
// of the byte stream and the master of the memory write port.
interface prog_loader_if;
  import loader_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 prog_we;
  logic [ADDR_BITS-1:0] prog_addr;
  logic [WORD_BITS-1:0] prog_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  prog_we,
    input  prog_addr,
    input  prog_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output prog_we,
    output prog_addr,
    output prog_wdata
  );

endinterface

// File: rtl/prog_loader.sv
// Parses HEADER, LEN, LEN x {opcode, operand}, CSUM from a byte stream, writes
// each word to instruction memory and holds the CPU in reset until an image checks out.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [DATA_BITS-1:0] HEADER    = HEADER_DEFAULT,
  parameter int unsigned          MAX_WORDS = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  prog_loader_if.slave          bus,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [COUNT_BITS-1:0] word_count
);

  loader_state_e        state;
  logic [COUNT_BITS-1:0] len;
  logic [DATA_BITS-1:0]  opcode;
  logic [DATA_BITS-1:0]  checksum;
  logic                  accept;
  logic                  is_header;
  logic                  len_bad;
  logic                  last_word;

  assign accept    = bus.rx_valid & bus.rx_ready;
  assign is_header = (bus.rx_data == HEADER);
  assign len_bad   = (bus.rx_data == '0) || (32'(bus.rx_data) > MAX_WORDS);
  assign last_word = ((word_count + COUNT_BITS'(1)) == len);

  // Frame parser; every output is a register updated alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      len            <= '0;
      opcode         <= '0;
      checksum       <= '0;
      word_count     <= '0;
      cpu_reset      <= 1'b1;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
      bus.rx_ready   <= 1'b1;
      bus.prog_we    <= 1'b0;
      bus.prog_addr  <= '0;
      bus.prog_wdata <= '0;
    end else begin
      bus.prog_we  <= 1'b0;
      bus.rx_ready <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept && is_header) begin
            state     <= ST_LEN;
            cpu_reset <= 1'b1;
          end
        end

        ST_LEN: begin
          if (accept) begin
            if (len_bad) begin
              state      <= ST_ERR;
              load_error <= 1'b1;
            end else begin
              len        <= COUNT_BITS'(bus.rx_data);
              word_count <= '0;
              checksum   <= bus.rx_data;
              state      <= ST_HI;
            end
          end
        end

        ST_HI: begin
          if (accept) begin
            opcode   <= bus.rx_data;
            checksum <= checksum + bus.rx_data;
            state    <= ST_LO;
          end
        end

        // Launch the write so prog_we is high for exactly the WRITE cycle.
        ST_LO: begin
          if (accept) begin
            checksum       <= checksum + bus.rx_data;
            bus.prog_we    <= 1'b1;
            bus.prog_addr  <= ADDR_BITS'(word_count);
            bus.prog_wdata <= prog_word_t'{opcode: opcode, operand: bus.rx_data};
            bus.rx_ready   <= 1'b0;
            state          <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          word_count <= word_count + COUNT_BITS'(1);
          state      <= last_word ? ST_CSUM : ST_HI;
        end

        ST_CSUM: begin
          if (accept) begin
            if (bus.rx_data == checksum) begin
              state     <= ST_DONE;
              load_done <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state      <= ST_ERR;
              load_error <= 1'b1;
            end
          end
        end

        // A new header restarts loading from either terminal state.
        ST_DONE, ST_ERR: begin
          if (accept && is_header) begin
            state      <= ST_LEN;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            cpu_reset  <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frame table, hand-written
// reset and long-frame sequences, and randomized streams against a frame-level model.
module tb_prog_loader;

  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         MAXW = 255;

  logic       clock;
  logic       reset;
  logic       cpu_reset;
  logic       load_done;
  logic       load_error;
  logic [7:0] word_count;

  prog_loader_if bus ();

  prog_loader #(.HEADER(HDR), .MAX_WORDS(MAXW)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .word_count (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  byte unsigned stim[$];
  logic [23:0]  got_w[$];
  logic [23:0]  exp_w[$];
  logic         exp_done;
  logic         exp_err;
  int           exp_wc;

  int   ready_bad = 0;
  int   dbl_we    = 0;
  logic prev_we   = 1'b0;

  // Record every strobe as {addr, wdata} and watch strobe/ready rules.
  always @(posedge clock) begin
    if (bus.prog_we) begin
      got_w.push_back({bus.prog_addr, bus.prog_wdata});
      if (bus.rx_ready) ready_bad++;
      if (prev_we) dbl_we++;
    end
    prev_we <= bus.prog_we;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset        = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_byte(input byte unsigned b, input bit burst);
    int gaps;
    int guard;
    gaps = burst ? 0 : int'($urandom_range(0, 2));
    repeat (gaps) begin
      @(negedge clock);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    @(negedge clock);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    guard = 0;
    while (!bus.rx_ready && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 8) check("rx_ready_timeout", 32'(guard), 32'(0));
  endtask

  task automatic send_stim(input bit burst);
    foreach (stim[i]) send_byte(stim[i], burst);
    @(negedge clock);
    bus.rx_valid = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Frame-level reference: walk the byte list by index, not by state.
  task automatic run_model();
    int p;
    int len;
    int n;
    byte unsigned sum;
    bit partial;
    exp_w.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_wc   = 0;
    n = stim.size();
    p = 0;
    while (p < n) begin
      if (stim[p] != HDR) begin
        p++;
        continue;
      end
      p++;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (p >= n) break;
      len = int'(stim[p]);
      p++;
      if (len == 0 || len > MAXW) begin
        exp_err = 1'b1;
        continue;
      end
      exp_wc  = 0;
      sum     = 8'(len);
      partial = 1'b0;
      for (int k = 0; k < len; k++) begin
        if (p + 1 >= n) begin
          partial = 1'b1;
          break;
        end
        exp_w.push_back({8'(k), stim[p], stim[p+1]});
        sum    = 8'(sum + stim[p] + stim[p+1]);
        exp_wc = k + 1;
        p += 2;
      end
      if (partial || p >= n) break;
      if (stim[p] == sum) exp_done = 1'b1;
      else                exp_err  = 1'b1;
      p++;
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 32'(got_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check({tag, "_write"}, 32'(got_w[i]), 32'(exp_w[i]));
  endtask

  typedef struct {
    int           n;
    logic [127:0] data;
    bit           burst;
    logic         exp_done;
    logic         exp_err;
    logic         exp_cpu;
    int           exp_wc;
    int           exp_nw;
  } vec_t;

  vec_t vecs[7];

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    vecs[0] = '{7,  128'hA5_02_10_05_20_06_3D,             1'b0, 1'b1, 1'b0, 1'b0, 2, 2};
    vecs[1] = '{7,  128'hA5_02_10_05_20_06_3E,             1'b0, 1'b0, 1'b1, 1'b1, 2, 2};
    vecs[2] = '{7,  128'h00_FF_A5_01_30_07_38,             1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
    vecs[3] = '{2,  128'hA5_00,                            1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[4] = '{12, 128'hA5_02_10_05_20_06_3D_A5_01_30_07_38, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3};
    vecs[5] = '{7,  128'hA5_02_10_05_20_06_3D,             1'b1, 1'b1, 1'b0, 1'b0, 2, 2};
    vecs[6] = '{9,  128'hA5_03_01_02_03_04_05_06_18,       1'b1, 1'b1, 1'b0, 1'b0, 3, 3};

    // Reset values
    do_reset();
    check("rst_rx_ready",   32'(bus.rx_ready),   32'(1));
    check("rst_prog_we",    32'(bus.prog_we),    32'(0));
    check("rst_prog_addr",  32'(bus.prog_addr),  32'(0));
    check("rst_prog_wdata", 32'(bus.prog_wdata), 32'(0));
    check("rst_cpu_reset",  32'(cpu_reset),      32'(1));
    check("rst_load_done",  32'(load_done),      32'(0));
    check("rst_load_error", 32'(load_error),     32'(0));
    check("rst_word_count", 32'(word_count),     32'(0));

    // Directed frame table
    for (int v = 0; v < 7; v++) begin
      do_reset();
      got_w.delete();
      stim.delete();
      for (int i = 0; i < vecs[v].n; i++)
        stim.push_back(vecs[v].data[8*(vecs[v].n-1-i) +: 8]);
      send_stim(vecs[v].burst);
      run_model();
      check($sformatf("vec%0d_done", v),  32'(load_done),      32'(vecs[v].exp_done));
      check($sformatf("vec%0d_err", v),   32'(load_error),     32'(vecs[v].exp_err));
      check($sformatf("vec%0d_cpu", v),   32'(cpu_reset),      32'(vecs[v].exp_cpu));
      check($sformatf("vec%0d_wc", v),    32'(word_count),     32'(vecs[v].exp_wc));
      check($sformatf("vec%0d_nw", v),    32'(got_w.size()),   32'(vecs[v].exp_nw));
      compare_writes($sformatf("vec%0d", v));
    end
    check("vec0_first_word", 32'(exp_w.size() > 0 ? 24'h0 : 24'h1), 32'(0));

    // Reset in the middle of the second word
    do_reset();
    got_w.delete();
    stim = '{8'hA5, 8'h02, 8'h10, 8'h05, 8'h20};
    foreach (stim[i]) send_byte(stim[i], 1'b0);
    @(negedge clock);
    bus.rx_valid = 1'b0;
    reset        = 1'b1;
    repeat (2) @(negedge clock);
    check("mid_rx_ready",   32'(bus.rx_ready),   32'(1));
    check("mid_prog_we",    32'(bus.prog_we),    32'(0));
    check("mid_prog_addr",  32'(bus.prog_addr),  32'(0));
    check("mid_prog_wdata", 32'(bus.prog_wdata), 32'(0));
    check("mid_cpu_reset",  32'(cpu_reset),      32'(1));
    check("mid_done_err",   32'({load_done, load_error}), 32'(0));
    check("mid_word_count", 32'(word_count),     32'(0));
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_nwrites", 32'(got_w.size()), 32'(1));
    stim = '{8'hA5, 8'h02, 8'h10, 8'h05, 8'h20, 8'h06, 8'h3D};
    send_stim(1'b0);
    check("mid_reload_done", 32'(load_done),    32'(1));
    check("mid_total_nw",    32'(got_w.size()), 32'(3));
    if (got_w.size() == 3) begin
      check("mid_w0", 32'(got_w[0]), 32'(24'h00_1005));
      check("mid_w1", 32'(got_w[1]), 32'(24'h00_1005));
      check("mid_w2", 32'(got_w[2]), 32'(24'h01_2006));
    end

    // Longest legal image, streamed back to back
    do_reset();
    got_w.delete();
    stim.delete();
    begin
      byte unsigned s;
      stim.push_back(HDR);
      stim.push_back(8'd255);
      s = 8'd255;
      for (int k = 0; k < 510; k++) begin
        stim.push_back(8'(k * 7 + 3));
        s = 8'(s + 8'(k * 7 + 3));
      end
      stim.push_back(s);
    end
    send_stim(1'b1);
    run_model();
    check("max_done",  32'(load_done),  32'(1));
    check("max_wc",    32'(word_count), 32'(255));
    compare_writes("max");

    // Randomized streams against the model
    for (int t = 0; t < 30; t++) begin
      int nf;
      do_reset();
      got_w.delete();
      stim.delete();
      nf = int'($urandom_range(1, 3));
      for (int f = 0; f < nf; f++) begin
        int junk;
        int len;
        byte unsigned s;
        junk = int'($urandom_range(0, 2));
        for (int j = 0; j < junk; j++) begin
          byte unsigned jb;
          jb = 8'($urandom);
          if (jb == HDR) jb = 8'h5A;
          stim.push_back(jb);
        end
        stim.push_back(HDR);
        len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
        stim.push_back(8'(len));
        if (len == 0) continue;
        s = 8'(len);
        for (int k = 0; k < 2 * len; k++) begin
          byte unsigned pb;
          pb = 8'($urandom);
          stim.push_back(pb);
          s = 8'(s + pb);
        end
        stim.push_back(($urandom_range(0, 3) == 0) ? 8'(s + 8'd1) : s);
      end
      send_stim(t[0]);
      run_model();
      check($sformatf("rnd%0d_done", t), 32'(load_done),  32'(exp_done));
      check($sformatf("rnd%0d_err", t),  32'(load_error), 32'(exp_err));
      check($sformatf("rnd%0d_cpu", t),  32'(cpu_reset),  32'(!exp_done));
      check($sformatf("rnd%0d_wc", t),   32'(word_count), 32'(exp_wc));
      compare_writes($sformatf("rnd%0d", t));
    end

    check("ready_low_in_write", 32'(ready_bad), 32'(0));
    check("single_cycle_we",    32'(dbl_we),    32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
